// File: rtl/sys_irq_ctrl.sv
// System register window (0x2020-0x2027): sys control, joystick port, prescaled countdown
// timer, audio-DMA flag, periodic NMI and IRQ/NMI outputs. Optional macro: SYS_IRQ_AUTORELOAD_EN.
module sys_irq_ctrl #(
    parameter logic [7:0]  PRESCALE_FAST   = 8'hFF,
    parameter logic [13:0] PRESCALE_SLOW   = 14'h3FFF,
    parameter int unsigned NMI_PERIOD_LOG2 = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cpu_ce,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] joystick,
    input  logic       adma_done,
    output logic [7:0] sys_ctl,
    output logic       irq,
    output logic       nmi
);

    logic [7:0]                 r_sys_ctl;
    logic [7:0]                 r_timer;
    logic [13:0]                r_presc;
    logic [1:0]                 r_status;
    logic [NMI_PERIOD_LOG2-1:0] r_nmi_cnt;
    logic [7:0]                 r_dout;
    logic                       r_irq;
    logic                       r_nmi;

    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic        w_expire;
    logic        w_wr_timer;
    logic [13:0] w_presc_reload;
    logic [7:0]  w_timer_nxt;
    logic [1:0]  w_status_set;
    logic [1:0]  w_status_clr;
    logic [7:0]  w_rdata;
    logic        w_nmi_wrap;

`ifdef SYS_IRQ_AUTORELOAD_EN
    logic [7:0] r_reload;
    logic       r_reload_pend;
`endif

    assign w_wr           = cs & we;
    assign w_rd           = cs & ~we;
    assign w_wr_timer     = w_wr & (addr == 3'd3);
    assign w_tick         = cpu_ce & (r_presc == '0);
    assign w_presc_reload = r_sys_ctl[4] ? PRESCALE_SLOW : {6'b0, PRESCALE_FAST};
    assign w_nmi_wrap     = cpu_ce & (&r_nmi_cnt);

    // CPU write beats both the pending reload and a same-edge tick.
    always_comb begin
        w_timer_nxt = r_timer;
        w_expire    = 1'b0;
        if (w_wr_timer) begin
            w_timer_nxt = din;
        end
`ifdef SYS_IRQ_AUTORELOAD_EN
        else if (r_reload_pend) begin
            w_timer_nxt = r_reload;
        end
`endif
        else if (w_tick && (r_timer != 8'd0)) begin
            w_timer_nxt = r_timer - 8'd1;
            w_expire    = (r_timer == 8'd1);
        end
    end

    always_comb begin
        w_status_set    = '0;
        w_status_clr    = '0;
        w_status_set[0] = w_expire | (w_wr_timer & (din == 8'd0));
        w_status_set[1] = adma_done;
        w_status_clr[0] = w_rd & (addr == 3'd4);
        w_status_clr[1] = w_rd & (addr == 3'd5);
    end

    always_comb begin
        w_rdata = 8'hFF;
        case (addr)
            3'd0:    w_rdata = ~joystick;
            3'd3:    w_rdata = r_timer;
            3'd4:    w_rdata = 8'h00;
            3'd5:    w_rdata = 8'h00;
            3'd6:    w_rdata = r_sys_ctl;
            3'd7:    w_rdata = {6'b0, r_status};
            default: w_rdata = 8'hFF;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sys_ctl <= '0;
            r_timer   <= '0;
            r_presc   <= {6'b0, PRESCALE_FAST};
            r_status  <= '0;
            r_nmi_cnt <= '0;
            r_dout    <= '1;
            r_irq     <= 1'b0;
            r_nmi     <= 1'b0;
        end else begin
            if (w_wr && (addr == 3'd6)) begin
                r_sys_ctl <= din;
            end
            if (cpu_ce) begin
                r_presc   <= (r_presc != '0) ? (r_presc - 14'd1) : w_presc_reload;
                r_nmi_cnt <= r_nmi_cnt + 1'b1;
            end
            r_timer  <= w_timer_nxt;
            r_status <= w_status_set | (r_status & ~w_status_clr);
            if (w_rd) begin
                r_dout <= w_rdata;
            end
            r_irq <= (r_status[0] & r_sys_ctl[1]) | (r_status[1] & r_sys_ctl[2]);
            r_nmi <= w_nmi_wrap & r_sys_ctl[0];
        end
    end

`ifdef SYS_IRQ_AUTORELOAD_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_reload      <= '0;
            r_reload_pend <= 1'b0;
        end else begin
            if (w_wr_timer) begin
                r_reload <= din;
            end
            r_reload_pend <= w_expire & r_sys_ctl[7] & (r_reload != 8'd0);
        end
    end
`endif

    assign dout    = r_dout;
    assign sys_ctl = r_sys_ctl;
    assign irq     = r_irq;
    assign nmi     = r_nmi;

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// Directed self-checking bench for sys_irq_ctrl with shortened prescaler/NMI periods.
module tb_sys_irq_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       cpu_ce;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] joystick;
    logic       adma_done;
    logic [7:0] sys_ctl;
    logic       irq;
    logic       nmi;

    int n_checks = 0;
    int n_errors = 0;

    sys_irq_ctrl #(
        .PRESCALE_FAST   (8'd3),
        .PRESCALE_SLOW   (14'd7),
        .NMI_PERIOD_LOG2 (4)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cpu_ce    (cpu_ce),
        .cs        (cs),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .joystick  (joystick),
        .adma_done (adma_done),
        .sys_ctl   (sys_ctl),
        .irq       (irq),
        .nmi       (nmi)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        cycle();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        cs = 1'b1; we = 1'b0; addr = a;
        cycle();
        cs = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_ce = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
        joystick = 8'h05; adma_done = 1'b0;
        #1;
        cycle(); cycle();
        chk("rst_dout", dout, 8'hFF);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_nmi", {7'b0, nmi}, 8'h00);
        chk("rst_ctl", sys_ctl, 8'h00);
        reset = 1'b0;

        rd(3'd0); chk("rd_joy", dout, 8'hFA);
        rd(3'd3); chk("rd_timer0", dout, 8'h00);
        rd(3'd6); chk("rd_ctl0", dout, 8'h00);
        rd(3'd7); chk("rd_stat0", dout, 8'h00);
        rd(3'd1); chk("rd_unmapped", dout, 8'hFF);

        // Countdown: prescaler period 4 ticks, timer 2 -> expiry on 8th ce edge
        wr(3'd6, 8'h02);
        wr(3'd3, 8'h02);
        cpu_ce = 1'b1;
        repeat (4) cycle();
        rd(3'd3); chk("timer_mid", dout, 8'h01);
        repeat (2) cycle();
        chk("irq_pre7", {7'b0, irq}, 8'h00);
        cycle();
        chk("irq_at_exp", {7'b0, irq}, 8'h00);
        cycle();
        chk("irq_after_exp", {7'b0, irq}, 8'h01);
        cpu_ce = 1'b0;
        rd(3'd3); chk("timer_hold0", dout, 8'h00);
        rd(3'd7); chk("stat_t", dout, 8'h01);
        rd(3'd4);
        chk("ack4_dout", dout, 8'h00);
        chk("ack4_irq_lag", {7'b0, irq}, 8'h01);
        cycle();
        chk("ack4_irq_low", {7'b0, irq}, 8'h00);
        rd(3'd7); chk("stat_clr", dout, 8'h00);

        // Writing zero sets status immediately
        wr(3'd3, 8'h00);
        chk("wr0_irq_lag", {7'b0, irq}, 8'h00);
        cycle();
        chk("wr0_irq", {7'b0, irq}, 8'h01);
        wr(3'd6, 8'h00);
        chk("dis_irq_lag", {7'b0, irq}, 8'h01);
        cycle();
        chk("dis_irq_low", {7'b0, irq}, 8'h00);
        rd(3'd7); chk("dis_keeps_stat", dout, 8'h01);
        rd(3'd4);

        // ADMA set beats ack on the same edge
        wr(3'd6, 8'h04);
        cs = 1'b1; we = 1'b0; addr = 3'd5; adma_done = 1'b1;
        cycle();
        cs = 1'b0; adma_done = 1'b0;
        chk("adma_coll_irq_lag", {7'b0, irq}, 8'h00);
        cycle();
        chk("adma_irq", {7'b0, irq}, 8'h01);
        rd(3'd7); chk("adma_stat", dout, 8'h02);
        rd(3'd5);
        chk("adma_ack_lag", {7'b0, irq}, 8'h01);
        cycle();
        chk("adma_ack_low", {7'b0, irq}, 8'h00);
        rd(3'd7); chk("adma_stat_clr", dout, 8'h00);

        // Reset mid-activity drops pending irq and control
        wr(3'd6, 8'h02);
        wr(3'd3, 8'h00);
        cycle();
        chk("pre_rst_irq", {7'b0, irq}, 8'h01);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_irq", {7'b0, irq}, 8'h00);
        chk("mid_rst_ctl", sys_ctl, 8'h00);
        chk("mid_rst_dout", dout, 8'hFF);

        // NMI every 16 ce when enabled
        wr(3'd6, 8'h01);
        cpu_ce = 1'b1;
        repeat (15) cycle();
        chk("nmi_pre", {7'b0, nmi}, 8'h00);
        cycle();
        chk("nmi_pulse1", {7'b0, nmi}, 8'h01);
        cycle();
        chk("nmi_one_cycle", {7'b0, nmi}, 8'h00);
        repeat (14) cycle();
        chk("nmi_pre2", {7'b0, nmi}, 8'h00);
        cycle();
        chk("nmi_pulse2", {7'b0, nmi}, 8'h01);
        wr(3'd6, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk("nmi_disabled", {7'b0, nmi}, 8'h00);
        end
        cpu_ce = 1'b0;

        // Auto-reload control bit: stored always, effective only with the macro
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wr(3'd6, 8'h82);
        rd(3'd6); chk("ctl_b7", dout, 8'h82);
        wr(3'd3, 8'h01);
        cpu_ce = 1'b1;
        repeat (4) cycle();
        cpu_ce = 1'b0;
        cycle(); cycle();
`ifdef SYS_IRQ_AUTORELOAD_EN
        rd(3'd3); chk("autoreload_timer", dout, 8'h01);
`else
        rd(3'd3); chk("no_autoreload_timer", dout, 8'h00);
`endif
        rd(3'd7); chk("autoreload_stat", dout, 8'h01);
        rd(3'd4);

        // Slow prescaler: after a reload with sys_ctl[4]=1 the period is 8 ce
        wr(3'd6, 8'h12);
        wr(3'd3, 8'h01);
        cpu_ce = 1'b1;
        repeat (4) cycle();
        cpu_ce = 1'b0;
        rd(3'd4);
        cycle();
        wr(3'd3, 8'h01);
        cpu_ce = 1'b1;
        repeat (7) cycle();
        cpu_ce = 1'b0;
        rd(3'd7); chk("slow_not_yet", dout, 8'h00);
        cpu_ce = 1'b1;
        cycle();
        cpu_ce = 1'b0;
        rd(3'd7); chk("slow_expired", dout, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
